// File: rtl/minterm_sweeper.sv
// Clocked sweeper for a 4-input SoP/PoS function unit: drives all 16 minterms,
// samples both outputs after a settle delay and checks them against each other and a mask.
module minterm_sweeper #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        sope_in,
  input  logic        pose_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] sop_table,
  output logic [15:0] pos_table,
  output logic [15:0] err_mask,
  output logic        mismatch,
  output logic [3:0]  first_err,
  output logic [4:0]  ones_count,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // SETTLE=0 skips WAIT entirely, so the terminal count is only used for SETTLE>0
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic       ZERO_SETTLE = (SETTLE == 0) ? 1'b1 : 1'b0;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  idx_r;
  logic [15:0] exp_r;
  logic [15:0] sop_table_r;
  logic [15:0] pos_table_r;
  logic [15:0] err_mask_r;
  logic        mismatch_r;
  logic [3:0]  first_err_r;
  logic [4:0]  ones_count_r;
  logic        pass_r;
  logic        busy_r;
  logic        done_r;

  logic [15:0] idx_onehot_s;
  logic        sop_ne_pos_s;
  logic        sop_ne_exp_s;
  logic        err_bit_s;
  logic [15:0] err_next_s;
  logic        first_hit_s;
  state_t      after_drive_s;

  // Per-sample error evaluation and the state entered after a new minterm is driven
  always_comb begin
    idx_onehot_s  = 16'h0001 << idx_r;
    sop_ne_pos_s  = sope_in ^ pose_in;
    sop_ne_exp_s  = sope_in ^ exp_r[idx_r];
    err_bit_s     = sop_ne_pos_s | sop_ne_exp_s;
    if (err_bit_s) begin
      err_next_s = err_mask_r | idx_onehot_s;
    end else begin
      err_next_s = err_mask_r & ~idx_onehot_s;
    end
    first_hit_s   = err_bit_s & (err_mask_r == 16'h0000);
    if (ZERO_SETTLE) begin
      after_drive_s = S_SAMPLE;
    end else begin
      after_drive_s = S_WAIT;
    end
  end

  // Sweep controller with all result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 4'd0;
      idx_r        <= 4'd0;
      exp_r        <= 16'h0000;
      sop_table_r  <= 16'h0000;
      pos_table_r  <= 16'h0000;
      err_mask_r   <= 16'h0000;
      mismatch_r   <= 1'b0;
      first_err_r  <= 4'd0;
      ones_count_r <= 5'd0;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            idx_r        <= 4'd0;
            cnt_r        <= 4'd0;
            exp_r        <= expected;
            sop_table_r  <= 16'h0000;
            pos_table_r  <= 16'h0000;
            err_mask_r   <= 16'h0000;
            mismatch_r   <= 1'b0;
            first_err_r  <= 4'd0;
            ones_count_r <= 5'd0;
            pass_r       <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= after_drive_s;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == SETTLE_LAST) begin
            state_r <= S_SAMPLE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_SAMPLE: begin
          if (sope_in) begin
            sop_table_r <= sop_table_r | idx_onehot_s;
          end else begin
            sop_table_r <= sop_table_r & ~idx_onehot_s;
          end
          if (pose_in) begin
            pos_table_r <= pos_table_r | idx_onehot_s;
          end else begin
            pos_table_r <= pos_table_r & ~idx_onehot_s;
          end
          ones_count_r <= ones_count_r + {4'd0, sope_in};
          err_mask_r   <= err_next_s;
          mismatch_r   <= mismatch_r | sop_ne_pos_s;
          if (first_hit_s) begin
            first_err_r <= idx_r;
          end else begin
            first_err_r <= first_err_r;
          end
          // idx stays at 15 after the final sample; only a new start rewinds it
          if (idx_r == 4'd15) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 16'h0000);
            state_r <= S_DONE;
          end else begin
            idx_r   <= idx_r + 4'd1;
            cnt_r   <= 4'd0;
            state_r <= after_drive_s;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign x          = idx_r[3];
  assign y          = idx_r[2];
  assign w          = idx_r[1];
  assign z          = idx_r[0];
  assign idx        = idx_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sop_table  = sop_table_r;
  assign pos_table  = pos_table_r;
  assign err_mask   = err_mask_r;
  assign mismatch   = mismatch_r;
  assign first_err  = first_err_r;
  assign ones_count = ones_count_r;
  assign pass       = pass_r;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench for minterm_sweeper: a behavioural function unit feeds the DUT,
// expected result vectors are queued at start and compared when done pulses.
module tb_minterm_sweeper;

  typedef logic [58:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        start = 1'b0;
  logic [15:0] expected = 16'h0000;
  logic        sope, pose, x, y, w, z, busy, done, mismatch, pass;
  logic [3:0]  idx, first_err;
  logic [15:0] sop_table, pos_table, err_mask;
  logic [4:0]  ones_count;

  // SETTLE=3 instance
  logic        start3 = 1'b0;
  logic [15:0] expected3 = 16'h0000;
  logic        sope3, pose3, x3, y3, w3, z3, busy3, done3, mismatch3, pass3;
  logic [3:0]  idx3, first_err3;
  logic [15:0] sop_table3, pos_table3, err_mask3;
  logic [4:0]  ones_count3;

  logic [15:0] fu_tt = 16'hE5AB;
  logic        force_pos0 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  res_t sb_q[$];

  assign sope  = fu_tt[{x, y, w, z}];
  assign pose  = force_pos0 ? 1'b0 : fu_tt[{x, y, w, z}];
  assign sope3 = fu_tt[{x3, y3, w3, z3}];
  assign pose3 = force_pos0 ? 1'b0 : fu_tt[{x3, y3, w3, z3}];

  wire res_t act_res  = {sop_table, pos_table, err_mask, mismatch, first_err, ones_count, pass};
  wire res_t act_res3 = {sop_table3, pos_table3, err_mask3, mismatch3, first_err3, ones_count3, pass3};

  minterm_sweeper #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
    .sope_in(sope), .pose_in(pose), .x(x), .y(y), .w(w), .z(z), .idx(idx),
    .busy(busy), .done(done), .sop_table(sop_table), .pos_table(pos_table),
    .err_mask(err_mask), .mismatch(mismatch), .first_err(first_err),
    .ones_count(ones_count), .pass(pass)
  );

  minterm_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected3),
    .sope_in(sope3), .pose_in(pose3), .x(x3), .y(y3), .w(w3), .z(z3), .idx(idx3),
    .busy(busy3), .done(done3), .sop_table(sop_table3), .pos_table(pos_table3),
    .err_mask(err_mask3), .mismatch(mismatch3), .first_err(first_err3),
    .ones_count(ones_count3), .pass(pass3)
  );

  // Reference: result fields derived bit by bit from the sampled truth tables
  function automatic res_t model(input logic [15:0] stt, input logic [15:0] ptt, input logic [15:0] ex);
    logic [15:0] err;
    logic        mm;
    logic [3:0]  fe;
    logic [4:0]  ones;
    logic        found;
    err = 16'h0000; mm = 1'b0; fe = 4'd0; ones = 5'd0; found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (stt[i]) ones = ones + 5'd1;
      err[i] = (stt[i] != ex[i]) || (stt[i] != ptt[i]);
      if (stt[i] != ptt[i]) mm = 1'b1;
      if (err[i] && !found) begin
        fe = 4'(i);
        found = 1'b1;
      end
    end
    return {stt, ptt, err, mm, fe, ones, (err == 16'h0000)};
  endfunction

  task automatic start_sweep(input logic [15:0] ex);
    repeat (2) @(negedge clk);
    expected = ex;
    start = 1'b1;
    sb_q.push_back(model(fu_tt, force_pos0 ? 16'h0000 : fu_tt, ex));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({x, y, w, z, idx, busy, done} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 0", {x, y, w, z, idx, busy, done});
    end
    vectors++;
    if (act_res !== 59'd0) begin
      miscompares++;
      $display("FAIL reset_results: got %h, want 0", act_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct_unit;
    int n; bit got; res_t e;
    fu_tt = 16'hE5AB; force_pos0 = 1'b0;
    start_sweep(16'hE5AB);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL correct_busy_rise: got %b, want 1", busy);
    end
    wait_done(40, n, got);
    vectors++;
    if (!got || n != 32) begin
      miscompares++;
      $display("FAIL correct_latency: got %0d edges (done seen %0d), want 32", n, got);
    end
    e = sb_q.pop_front();
    vectors++;
    if (act_res !== e) begin
      miscompares++;
      $display("FAIL correct_results: got %h, want %h", act_res, e);
    end
    vectors++;
    if ({sop_table, pos_table, ones_count, pass, busy} !== {16'hE5AB, 16'hE5AB, 5'd10, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL correct_const: got %h %h %0d %b %b, want e5ab e5ab 10 1 0",
               sop_table, pos_table, ones_count, pass, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({idx, done} !== {4'd15, 1'b0}) begin
      miscompares++;
      $display("FAIL correct_after_done: got idx=%0d done=%b, want idx=15 done=0", idx, done);
    end
  endtask

  task automatic test_expected_error;
    int n; bit got; res_t e;
    start_sweep(16'hE5AA);
    wait_done(40, n, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || act_res !== e) begin
      miscompares++;
      $display("FAIL experr_results: got %h (done %0d), want %h", act_res, got, e);
    end
    vectors++;
    if ({err_mask, first_err, pass, mismatch} !== {16'h0001, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL experr_const: got %h %0d %b %b, want 0001 0 0 0", err_mask, first_err, pass, mismatch);
    end
  endtask

  task automatic test_pos_stuck;
    int n; bit got; res_t e;
    force_pos0 = 1'b1;
    start_sweep(16'hE5AB);
    wait_done(40, n, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || act_res !== e) begin
      miscompares++;
      $display("FAIL posstuck_results: got %h (done %0d), want %h", act_res, got, e);
    end
    vectors++;
    if ({pos_table, mismatch, err_mask, first_err, pass} !== {16'h0000, 1'b1, 16'hE5AB, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL posstuck_const: got %h %b %h %0d %b, want 0000 1 e5ab 0 0",
               pos_table, mismatch, err_mask, first_err, pass);
    end
    force_pos0 = 1'b0;
  endtask

  task automatic test_drive_order;
    bit seq_ok; res_t e;
    seq_ok = 1'b1;
    repeat (2) @(negedge clk);
    expected3 = 16'hE5AB;
    start3 = 1'b1;
    sb_q.push_back(model(fu_tt, fu_tt, 16'hE5AB));
    @(posedge clk);
    #1;
    start3 = 1'b0;
    // sample after accept edge j: each minterm is held for 4 cycles
    for (int j = 0; j < 64; j++) begin
      if ({x3, y3, w3, z3} !== 4'(j / 4) || idx3 !== 4'(j / 4) || done3 !== 1'b0) seq_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (!seq_ok) begin
      miscompares++;
      $display("FAIL order_sequence: got drive order deviating, want idx/xywz = j/4 for 64 cycles");
    end
    vectors++;
    if (done3 !== 1'b1) begin
      miscompares++;
      $display("FAIL order_latency: got done=%b at edge 64, want 1", done3);
    end
    e = sb_q.pop_front();
    vectors++;
    if (act_res3 !== e) begin
      miscompares++;
      $display("FAIL order_results: got %h, want %h", act_res3, e);
    end
  endtask

  task automatic test_busy_restart;
    int dones; int first_done; res_t e;
    dones = 0; first_done = -1;
    start_sweep(16'hE5AB);
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = n;
      end
      start = (n == 5 || n == 12 || n == 25) ? 1'b1 : 1'b0;
    end
    e = sb_q.pop_front();
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL busy_done_count: got %0d, want 1", dones);
    end
    vectors++;
    if (first_done != 32) begin
      miscompares++;
      $display("FAIL busy_no_restart: got done at edge %0d, want 32", first_done);
    end
    vectors++;
    if (act_res !== e) begin
      miscompares++;
      $display("FAIL busy_results: got %h, want %h", act_res, e);
    end
  endtask

  task automatic test_start_held;
    int n; int d1; int d2; logic b1; logic b2; res_t e;
    d1 = -1; d2 = -1; b1 = 1'bx; b2 = 1'bx; n = 0;
    repeat (2) @(negedge clk);
    expected = 16'hE5AB;
    start = 1'b1;
    sb_q.push_back(model(fu_tt, fu_tt, 16'hE5AB));
    sb_q.push_back(model(fu_tt, fu_tt, 16'hE5AB));
    @(posedge clk);
    #1;
    while (n < 100 && d2 < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (d1 >= 0 && n == d1 + 1) b1 = busy;
      if (d1 >= 0 && n == d1 + 2) b2 = busy;
      if (done) begin
        e = sb_q.pop_front();
        vectors++;
        if (act_res !== e) begin
          miscompares++;
          $display("FAIL held_results: got %h, want %h", act_res, e);
        end
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (d1 != 32 || d2 != 66) begin
      miscompares++;
      $display("FAIL held_done_edges: got %0d and %0d, want 32 and 66", d1, d2);
    end
    vectors++;
    if ({b1, b2} !== 2'b01) begin
      miscompares++;
      $display("FAIL held_reaccept: got busy %b then %b, want 0 then 1", b1, b2);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midsweep;
    int n; bit got; int dones; res_t e;
    start_sweep(16'hE5AB);
    n = 0;
    while (n < 40 && idx !== 4'd7) begin
      @(posedge clk);
      n++;
      #1;
    end
    vectors++;
    if (idx !== 4'd7) begin
      miscompares++;
      $display("FAIL midreset_reach_idx7: got idx=%0d, want 7", idx);
    end
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    vectors++;
    if ({x, y, w, z, idx, busy, done, act_res} !== 70'd0) begin
      miscompares++;
      $display("FAIL midreset_clear: got %b %h, want all 0", {x, y, w, z, idx, busy, done}, act_res);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got %0d active cycles, want 0", dones);
    end
    start_sweep(16'hE5AB);
    wait_done(40, n, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || n != 32 || act_res !== e) begin
      miscompares++;
      $display("FAIL midreset_fresh: got %0d edges %h, want 32 edges %h", n, act_res, e);
    end
  endtask

  initial begin
    test_reset();
    test_correct_unit();
    test_expected_error();
    test_pos_stuck();
    test_drive_order();
    test_busy_restart();
    test_start_held();
    test_reset_midsweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
